// File: rtl/tick_sequencer.sv
// tick_sequencer: round-robin shared prescaler emitting N ticks at the winner's divisor.
module tick_sequencer #(
  parameter int NREQ = 4,
  parameter int DIVW = 26,
  parameter int CNTW = 8,
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 inclk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DIVW-1:0] div,
  input  logic [NREQ*CNTW-1:0] nticks,
  output logic [NREQ-1:0]      gnt,
  output logic [OW-1:0]        owner,
  output logic                 busy,
  output logic                 tick,
  output logic                 scaled_clk,
  output logic [NREQ-1:0]      done
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [OW-1:0] owner_q, owner_d, last_q, last_d, pick;
  logic [DIVW-1:0] div_q, div_d, presc_q, presc_d, sel_div;
  logic [CNTW-1:0] n_q, n_d, tcnt_q, tcnt_d, sel_n;
  logic sclk_q, sclk_d, any, own_req;
  int j;

  assign own_req = req[owner_q];
  assign sel_div = div[owner_q*DIVW +: DIVW];
  assign sel_n   = nticks[owner_q*CNTW +: CNTW];

  // first pending requester strictly after last_q, wrapping
  always_comb begin
    pick = '0;
    any  = 1'b0;
    j    = 0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(last_q) + i) % NREQ;
      if (!any && req[j]) begin
        any  = 1'b1;
        pick = OW'(j);
      end
    end
  end

  assign tick = (state_q == RUN) && (presc_q == div_q - DIVW'(1)) && own_req;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    div_d   = div_q;
    n_d     = n_q;
    presc_d = presc_q;
    tcnt_d  = tcnt_q;
    sclk_d  = sclk_q;
    case (state_q)
      IDLE: if (any) begin
        owner_d = pick;
        state_d = LOAD;
      end
      LOAD: if (!own_req) begin
        state_d = IDLE;
        last_d  = owner_q;
      end else begin
        div_d   = (sel_div == '0) ? DIVW'(1) : sel_div;
        n_d     = sel_n;
        presc_d = '0;
        tcnt_d  = '0;
        sclk_d  = 1'b0;
        state_d = (sel_n == '0) ? DONE : RUN;
      end
      RUN: if (!own_req) begin
        state_d = IDLE;
        last_d  = owner_q;
        sclk_d  = 1'b0;
      end else if (tick) begin
        presc_d = '0;
        tcnt_d  = tcnt_q + CNTW'(1);
        sclk_d  = ~sclk_q;
        if (tcnt_q == n_q - CNTW'(1)) begin
          state_d = DONE;
          sclk_d  = 1'b0;
        end
      end else begin
        presc_d = presc_q + DIVW'(1);
      end
      default: begin
        state_d = IDLE;
        last_d  = owner_q;
        sclk_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NREQ - 1);
      div_q   <= DIVW'(1);
      n_q     <= '0;
      presc_q <= '0;
      tcnt_q  <= '0;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      div_q   <= div_d;
      n_q     <= n_d;
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      sclk_q  <= sclk_d;
    end
  end

  assign busy       = state_q != IDLE;
  assign owner      = owner_q;
  assign gnt        = busy ? NREQ'(1) << owner_q : '0;
  assign done       = (state_q == DONE) ? NREQ'(1) << owner_q : '0;
  assign scaled_clk = sclk_q && (state_q == RUN);
endmodule

// File: tb/tb_tick_sequencer.sv
// tb_tick_sequencer: directed vectors and corner-case sequences for tick_sequencer.
module tb_tick_sequencer;
  localparam int NREQ = 4;
  localparam int DIVW = 26;
  localparam int CNTW = 8;

  logic inclk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*DIVW-1:0] div = '0;
  logic [NREQ*CNTW-1:0] nticks = '0;
  logic [NREQ-1:0] gnt, done;
  logic [1:0] owner;
  logic busy, tick, scaled_clk;

  int tests = 0;
  int fails = 0;

  tick_sequencer #(.NREQ(NREQ), .DIVW(DIVW), .CNTW(CNTW)) dut (
    .inclk(inclk), .rst_n(rst_n), .req(req), .div(div), .nticks(nticks),
    .gnt(gnt), .owner(owner), .busy(busy), .tick(tick),
    .scaled_clk(scaled_clk), .done(done)
  );

  always #5 inclk = ~inclk;

  typedef struct {
    int idx;
    int dv;
    int n;
    int done_cyc;
    logic [31:0] tmask;
    logic [31:0] smask;
  } vec_t;

  vec_t v[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_ch(input int idx, input int dv, input int n);
    div[idx*DIVW +: DIVW]    = DIVW'(dv);
    nticks[idx*CNTW +: CNTW] = CNTW'(n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge inclk);
    rst_n = 1'b1;
    @(negedge inclk);
  endtask

  // cycle 0 is the negedge where req is raised with the DUT idle
  task automatic run_vec(input vec_t x, input int k);
    logic [31:0] tm, sm, dval;
    logic [NREQ-1:0] eg;
    int dc, gerr;
    tm = '0; sm = '0; dval = '0; dc = -1; gerr = 0;
    set_ch(x.idx, x.dv, x.n);
    req = NREQ'(1) << x.idx;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (tick) tm[c] = 1'b1;
      if (scaled_clk) sm[c] = 1'b1;
      if (done != '0 && dc < 0) begin
        dc   = c;
        dval = 32'(done);
      end
      eg = (c >= 1 && c <= x.done_cyc) ? NREQ'(1) << x.idx : '0;
      if (gnt !== eg) gerr++;
      if (c == 1) chk($sformatf("v%0d owner", k), 32'(owner), 32'(x.idx));
      if (dc >= 0) req = '0;
      if (dc >= 0 && c > dc + 1) break;
      @(negedge inclk);
    end
    req = '0;
    chk($sformatf("v%0d tick cycles", k), tm, x.tmask);
    chk($sformatf("v%0d sclk cycles", k), sm, x.smask);
    chk($sformatf("v%0d done cycle", k), 32'(dc), 32'(x.done_cyc));
    chk($sformatf("v%0d done value", k), dval, 32'(1) << x.idx);
    chk($sformatf("v%0d gnt errors", k), 32'(gerr), 32'd0);
    @(negedge inclk);
  endtask

  initial begin
    v[0] = '{1, 3, 4, 14, 32'h0000_2490, 32'h0000_38E0};
    v[1] = '{2, 0, 2,  4, 32'h0000_000C, 32'h0000_0008};
    v[2] = '{0, 5, 0,  2, 32'h0000_0000, 32'h0000_0000};
    v[3] = '{3, 1, 3,  5, 32'h0000_001C, 32'h0000_0008};
    v[4] = '{0, 2, 3,  8, 32'h0000_00A8, 32'h0000_0030};

    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset gnt", 32'(gnt), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset tick", 32'(tick), 32'd0);
    chk("reset sclk", 32'(scaled_clk), 32'd0);
    chk("reset owner", 32'(owner), 32'd0);
    @(negedge inclk);
    rst_n = 1'b1;
    @(negedge inclk);

    for (int k = 0; k < 5; k++) run_vec(v[k], k);

    // arbitration: 0 and 2 pending from reset, alternate owners
    do_reset();
    set_ch(0, 1, 1);
    set_ch(2, 1, 1);
    req = 4'b0101;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c == 1) chk("arb gnt c1", 32'(gnt), 32'h1);
      if (c == 3) chk("arb done c3", 32'(done), 32'h1);
      if (c == 4) chk("arb gnt c4", 32'(gnt), 32'h0);
      if (c == 5) chk("arb gnt c5", 32'(gnt), 32'h4);
      if (c == 5) chk("arb owner c5", 32'(owner), 32'd2);
      if (c == 7) chk("arb done c7", 32'(done), 32'h4);
      if (c == 9) chk("arb gnt c9", 32'(gnt), 32'h1);
      @(negedge inclk);
    end
    req = '0;
    repeat (3) @(negedge inclk);
    chk("arb idle", 32'(busy), 32'd0);

    // abort on the cycle a tick would fire
    begin
      int dseen;
      dseen = 0;
      set_ch(1, 4, 5);
      req = 4'b0010;
      for (int c = 0; c < 13; c++) begin
        if (c == 9) req = '0;
        #1;
        if (done != '0) dseen++;
        if (c == 5) chk("abort tick c5", 32'(tick), 32'd1);
        if (c == 7) chk("abort sclk c7", 32'(scaled_clk), 32'd1);
        if (c == 9) chk("abort tick c9", 32'(tick), 32'd0);
        if (c == 10) chk("abort busy c10", 32'(busy), 32'd0);
        if (c == 10) chk("abort gnt c10", 32'(gnt), 32'd0);
        if (c == 10) chk("abort sclk c10", 32'(scaled_clk), 32'd0);
        @(negedge inclk);
      end
      chk("abort no done", 32'(dseen), 32'd0);
    end

    // asynchronous reset in the middle of a burst
    set_ch(2, 3, 4);
    req = 4'b0100;
    repeat (6) @(negedge inclk);
    #1;
    chk("mid sclk before rst", 32'(scaled_clk), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst gnt", 32'(gnt), 32'd0);
    chk("rst sclk", 32'(scaled_clk), 32'd0);
    chk("rst tick", 32'(tick), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    req = '0;
    @(negedge inclk);
    rst_n = 1'b1;
    set_ch(0, 1, 1);
    set_ch(3, 1, 1);
    req = 4'b1001;
    @(negedge inclk);
    #1;
    chk("post rst gnt 0 over 3", 32'(gnt), 32'h1);
    req = '0;
    do_reset();
    req = 4'b1000;
    @(negedge inclk);
    #1;
    chk("post rst gnt 3 alone", 32'(gnt), 32'h8);
    chk("post rst owner 3", 32'(owner), 32'd3);
    req = '0;
    repeat (3) @(negedge inclk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
